// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported, fixed-latency memory: fetch reads and
// memory-stage reads/writes take turns, with per-port stall/done and a halt-time dump.
module mem_port_arbiter #(
  parameter int LATENCY = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  output logic          if_done,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          dm_done,
  input  logic          halt,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_dump
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HALTED} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t        state, state_nxt;
  logic [3:0]    cnt_q;
  logic          gnt_data_q;
  logic          last_data_q;
  logic          wr_q;
  logic          dump_q;
  logic          halt_pend_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic dm_pend;
  logic halt_now;
  logic grant_data;
  logic grant;
  logic active;
  logic capture;

  always_comb begin
    dm_pend    = dm_rd | dm_wr;
    halt_now   = halt | halt_pend_q;
    // On a tie the port that did not win last time goes first.
    grant_data = dm_pend & (~if_req | ~last_data_q);
    grant      = (state == IDLE) & ~halt_now & (dm_pend | if_req);
    active     = (state == ISSUE) | (state == WAIT) | (state == RESP);
    capture    = ~wr_q & (((state == ISSUE) & (LATENCY == 1)) |
                          ((state == WAIT) & (cnt_q == 4'd1)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (halt_now)
          state_nxt = HALTED;
        else if (dm_pend | if_req)
          state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state == ISSUE);
    mem_wr    = active & wr_q;
    mem_addr  = active ? addr_q : '0;
    mem_wdata = active ? wdata_q : '0;
    mem_dump  = dump_q;
    if_done   = (state == RESP) & ~gnt_data_q;
    dm_done   = (state == RESP) & gnt_data_q;
    if_stall  = if_req & ~if_done;
    dm_stall  = dm_pend & ~dm_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt_q       <= 4'd0;
      gnt_data_q  <= 1'b0;
      last_data_q <= 1'b0;
      wr_q        <= 1'b0;
      dump_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
    end else begin
      state  <= state_nxt;
      dump_q <= (state == IDLE) & halt_now;
      // A halt seen mid-transaction is remembered so the dump still follows.
      if (halt & active)
        halt_pend_q <= 1'b1;
      if (grant) begin
        gnt_data_q  <= grant_data;
        last_data_q <= grant_data;
        wr_q        <= grant_data & dm_wr;
      end
      if (state == ISSUE)
        cnt_q <= CNT_INIT;
      else if (state == WAIT)
        cnt_q <= cnt_q - 4'd1;
      if (capture) begin
        if (gnt_data_q)
          dm_rdata <= mem_rdata;
        else
          if_rdata <= mem_rdata;
      end
    end
  end

  // Address/write data are only visible while a transaction is active, so no reset needed.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_q  <= grant_data ? dm_addr : if_addr;
      wdata_q <= grant_data ? dm_wdata : '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a LATENCY=4 instance for most scenarios and a
// LATENCY=1 instance for back-to-back fetches.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, dm_rd, dm_wr, halt;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_stall, if_done, dm_stall, dm_done, mem_en, mem_wr, mem_dump;

  logic        if_req1;
  logic [15:0] if_addr1, mem_rdata1;
  logic [15:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic        if_stall1, if_done1, dm_stall1, dm_done1, mem_en1, mem_wr1, mem_dump1;

  int   checks = 0;
  int   errors = 0;
  logic dturn;

  mem_port_arbiter #(.LATENCY(4), .AW(16), .DW(16)) u4 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall), .if_done(if_done),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_stall(dm_stall), .dm_done(dm_done), .halt(halt),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_dump(mem_dump)
  );

  mem_port_arbiter #(.LATENCY(1), .AW(16), .DW(16)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_stall(if_stall1), .if_done(if_done1),
    .dm_rd(1'b0), .dm_wr(1'b0), .dm_addr(16'h0000), .dm_wdata(16'h0000), .dm_rdata(dm_rdata1),
    .dm_stall(dm_stall1), .dm_done(dm_done1), .halt(1'b0),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .mem_dump(mem_dump1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; halt = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    if_req1 = 1'b0; if_addr1 = '0; mem_rdata1 = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    #3;
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_if_done", if_done, 1'b0);
    chk("rst_dm_done", dm_done, 1'b0);
    chk("rst_dump", mem_dump, 1'b0);
    chk("rst_if_rdata", if_rdata, 16'h0);
    chk("rst_dm_rdata", dm_rdata, 16'h0);
    chk("rst_u1_mem_en", mem_en1, 1'b0);

    // single data read, LATENCY=4
    dm_rd = 1'b1; dm_addr = 16'h0010;
    for (int c = 0; c <= 5; c++) begin
      mem_rdata = (c == 4) ? 16'hBEEF : 16'h0000;
      #3;
      chk($sformatf("rd_en c%0d", c), mem_en, (c == 1));
      chk($sformatf("rd_wr c%0d", c), mem_wr, 1'b0);
      chk($sformatf("rd_addr c%0d", c), mem_addr, (c >= 1) ? 16'h0010 : 16'h0000);
      chk($sformatf("rd_stall c%0d", c), dm_stall, (c <= 4));
      chk($sformatf("rd_done c%0d", c), dm_done, (c == 5));
      if (c == 5) chk("rd_rdata", dm_rdata, 16'hBEEF);
      tick();
    end
    dm_rd = 1'b0;

    // rd and wr together behave as a write
    dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'h5555; mem_rdata = 16'h7777;
    for (int c = 0; c <= 5; c++) begin
      #3;
      if (c == 1) begin
        chk("rw_en", mem_en, 1'b1);
        chk("rw_wr", mem_wr, 1'b1);
        chk("rw_wdata", mem_wdata, 16'h5555);
      end
      chk($sformatf("rw_done c%0d", c), dm_done, (c == 5));
      if (c == 5) chk("rw_rdata_kept", dm_rdata, 16'hBEEF);
      tick();
    end
    dm_rd = 1'b0; dm_wr = 1'b0;

    // contention out of reset, both ports held: D, I, D, I
    do_reset();
    if_req = 1'b1; if_addr = 16'h0100;
    dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234; mem_rdata = 16'hCAFE;
    for (int c = 0; c < 24; c++) begin
      dturn = ((c / 6) % 2 == 0);
      #3;
      chk($sformatf("arb_en c%0d", c), mem_en, (c % 6 == 1));
      if (c % 6 == 1) begin
        chk($sformatf("arb_addr c%0d", c), mem_addr, dturn ? 16'h0200 : 16'h0100);
        chk($sformatf("arb_wr c%0d", c), mem_wr, dturn);
        if (dturn) chk($sformatf("arb_wdata c%0d", c), mem_wdata, 16'h1234);
      end
      chk($sformatf("arb_dm_done c%0d", c), dm_done, (c % 6 == 5) && dturn);
      chk($sformatf("arb_if_done c%0d", c), if_done, (c % 6 == 5) && !dturn);
      chk($sformatf("arb_if_stall c%0d", c), if_stall, !((c % 6 == 5) && !dturn));
      if (c == 5)  chk("arb_dm_rdata_write", dm_rdata, 16'h0000);
      if (c == 11) chk("arb_if_rdata", if_rdata, 16'hCAFE);
      tick();
    end
    if_req = 1'b0; dm_wr = 1'b0;

    // halt during WAIT is deferred until the fetch completes
    if_req = 1'b1; if_addr = 16'h0040; mem_rdata = 16'h0000;
    for (int c = 0; c <= 12; c++) begin
      if (c == 2) halt = 1'b1;
      if (c == 6) if_req = 1'b0;
      if (c == 8) begin if_req = 1'b1; if_addr = 16'h0044; end
      #3;
      chk($sformatf("halt_dump c%0d", c), mem_dump, (c == 7));
      chk($sformatf("halt_en c%0d", c), mem_en, (c == 1));
      chk($sformatf("halt_done c%0d", c), if_done, (c == 5));
      if (c >= 8) begin
        chk($sformatf("halt_stall c%0d", c), if_stall, 1'b1);
        chk($sformatf("halt_addr c%0d", c), mem_addr, 16'h0000);
      end
      tick();
    end

    // reset in WAIT drops the transaction; next one has full latency
    do_reset();
    dm_rd = 1'b1; dm_addr = 16'h0060; mem_rdata = 16'h1111;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; dm_rd = 1'b0;
    #3;
    chk("rstw_en", mem_en, 1'b0);
    chk("rstw_addr", mem_addr, 16'h0000);
    chk("rstw_wr", mem_wr, 1'b0);
    chk("rstw_done", dm_done, 1'b0);
    chk("rstw_rdata", dm_rdata, 16'h0000);
    tick();
    dm_rd = 1'b1; dm_addr = 16'h0062;
    for (int c = 4; c <= 9; c++) begin
      mem_rdata = (c == 8) ? 16'h600D : 16'h1111;
      #3;
      chk($sformatf("rstw_en c%0d", c), mem_en, (c == 5));
      chk($sformatf("rstw_done c%0d", c), dm_done, (c == 9));
      if (c == 5) chk("rstw_addr2", mem_addr, 16'h0062);
      if (c == 9) chk("rstw_rdata2", dm_rdata, 16'h600D);
      tick();
    end
    dm_rd = 1'b0;

    // LATENCY=1: back-to-back fetches, one done every 3 cycles
    if_req1 = 1'b1; if_addr1 = 16'h0A00;
    for (int c = 0; c < 12; c++) begin
      if (c > 0 && c % 3 == 0) if_addr1 = 16'(16'h0A00 + c / 3);
      mem_rdata1 = 16'(16'hA000 + c);
      #3;
      chk($sformatf("l1_done c%0d", c), if_done1, (c % 3 == 2));
      chk($sformatf("l1_en c%0d", c), mem_en1, (c % 3 == 1));
      if (c % 3 == 1) chk($sformatf("l1_addr c%0d", c), mem_addr1, 16'(16'h0A00 + c / 3));
      if (c % 3 == 2) chk($sformatf("l1_rdata c%0d", c), if_rdata1, 16'(16'hA000 + c - 1));
      tick();
    end
    if_req1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
